aes_cbc_ctrl: RTL and testbench
===============================

// Module: aes_cbc_ctrl
// PURPOSE
//  Initiator for the AES core's enable/mode/key/word -> result/done handshake. Accepts a message of
//  128-bit blocks on a valid/ready stream and runs each block through the AES core with CBC chaining.
//  Returns the result blocks on a valid/ready stream.
//  Sits between the signature datapath and the AES core; the only block that drives the core's inputs.
// PARAMETERS
//  KEY_BW   256   AES key width
//  WORD_BW  128   AES block width
//  LEN_BW   16    width of block count
//  TIMEOUT  64    max cycles in RUN awaiting aes_done before error
// PORTS
//  clk          in   1        clock, rising edge
//  srst_n       in   1        reset, asynchronous, active-low
//  start        in   1        pulse: begin message (ignored unless IDLE)
//  mode_in      in   1        0=encrypt, 1=decrypt; sampled on start
//  key_in       in   KEY_BW   key; sampled on start
//  iv_in        in   WORD_BW  CBC IV; sampled on start
//  num_blocks   in   LEN_BW   blocks in message; sampled on start
//  in_valid     in   1        input block valid
//  in_data      in   WORD_BW  input block (plaintext or ciphertext)
//  in_ready     out  1        controller accepts in_data this cycle
//  out_valid    out  1        result block valid
//  out_data     out  WORD_BW  result block
//  out_ready    in   1        downstream accepts out_data
//  busy         out  1        state != IDLE
//  msg_done     out  1        1-cycle pulse: last block handed off
//  timeout_err  out  1        sticky: AES core failed to answer in TIMEOUT cycles
//  aes_enable   out  1        to core enable
//  aes_mode     out  1        to core mode
//  aes_key      out  KEY_BW   to core key
//  aes_word     out  WORD_BW  to core word
//  aes_result   in   WORD_BW  from core result
//  aes_done     in   1        from core done
// BEHAVIOUR
//  Reset: all outputs 0. All registers 0. State IDLE. Async reset mid-message aborts it; no msg_done.
//  States:
//  IDLE    start -> latch mode/key/iv->chain/num_blocks->remain.
//          num_blocks==0: pulse msg_done next cycle, stay IDLE. Else -> WAIT_IN.
//  WAIT_IN in_ready=1. On in_valid:
//          enc: word_r=in_data^chain.
//          dec: word_r=in_data, cin_r=in_data.
//          -> RUN; tcnt=0.
//  RUN     aes_enable=1.
//          aes_done=1 -> res_r = enc ? aes_result : aes_result^chain;
//                        chain = enc ? aes_result : cin_r; -> OUT.
//          else tcnt++. tcnt==TIMEOUT-1 without done -> ERR.
//  OUT     out_valid=1, out_data=res_r held stable until out_ready.
//          On out_ready: remain--. remain==1 -> msg_done pulse, -> IDLE. Else -> WAIT_IN.
//  ERR     timeout_err=1, aes_enable=0, in_ready=0. start clears error and begins a new message.
//  Core interface: aes_mode/aes_key/aes_word are registered and stable for whole RUN.
//   - aes_enable is low outside RUN, so low >=2 cycles between blocks (core re-arms).
//   - aes_done seen outside RUN is ignored.
//  in_ready/out_valid never both 1. One block in flight. start while busy has no effect.
//  Latency per block: 1 (accept) + core latency + 1 (capture) to out_valid.
//  remain is LEN_BW wide; no wrap: num_blocks=2^LEN_BW-1 runs fully.
// TESTING
//  Core stub for these vectors: aes_done after 20 cycles, returning the FIPS-197 AES-256 result.
//  Key K=000102..1f; P1=00112233445566778899aabbccddeeff; C1=8ea2b7ca516745bfeafc49904b496089.
//  1 enc block, iv=0, key=K, in=P1 -> out_data=C1, msg_done 1 cycle after out_ready.
//  2 enc blocks, iv=0, in=P1 then P2=8eb395f9153223c86265e32b87948e76 -> aes_word both P1; outs C1,C1.
//  2 dec blocks, iv=0, in=C1,C1 -> out P1 then P2; chain stays C1.
//  out_ready low 10 cycles in OUT -> out_data stable, in_ready=0, no new aes_enable; resumes after.
//  Core stub never asserts aes_done -> timeout_err=1 after 64 RUN cycles; start clears it.
//  num_blocks=0 -> msg_done pulse, aes_enable never 1. srst_n low mid-RUN -> all outputs 0 at once.

Source files
------------

// File: rtl/aes_cbc_ctrl_if.sv
// Handshake bundle between the CBC controller (master) and the AES core (slave).
// The controller owns enable/mode/key/word; the core answers with result/done.
interface aes_cbc_ctrl_if #(
    parameter int KEY_BW  = 256,
    parameter int WORD_BW = 128
);
    logic               aes_enable;
    logic               aes_mode;
    logic [KEY_BW-1:0]  aes_key;
    logic [WORD_BW-1:0] aes_word;
    logic [WORD_BW-1:0] aes_result;
    logic               aes_done;

    modport master (
        output aes_enable,
        output aes_mode,
        output aes_key,
        output aes_word,
        input  aes_result,
        input  aes_done
    );

    modport slave (
        input  aes_enable,
        input  aes_mode,
        input  aes_key,
        input  aes_word,
        output aes_result,
        output aes_done
    );
endinterface

// File: rtl/aes_cbc_ctrl.sv
// CBC-mode sequencer for an AES core: takes a message of 128-bit blocks on a
// valid/ready stream, runs each through the core one at a time and streams the results out.
module aes_cbc_ctrl #(
    parameter int KEY_BW  = 256,
    parameter int WORD_BW = 128,
    parameter int LEN_BW  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               srst_n,
    input  logic               start,
    input  logic               mode_in,
    input  logic [KEY_BW-1:0]  key_in,
    input  logic [WORD_BW-1:0] iv_in,
    input  logic [LEN_BW-1:0]  num_blocks,
    input  logic               in_valid,
    input  logic [WORD_BW-1:0] in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [WORD_BW-1:0] out_data,
    input  logic               out_ready,
    output logic               busy,
    output logic               msg_done,
    output logic               timeout_err,
    aes_cbc_ctrl_if.master     core
);

    localparam int TCNT_BW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TCNT_BW-1:0] TCNT_LAST = TCNT_BW'(TIMEOUT - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WAIT_IN = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_OUT     = 3'd3;
    localparam logic [2:0] ST_ERR     = 3'd4;

    logic [2:0]         state_reg;
    logic [2:0]         state_next;
    logic               mode_reg;
    logic [KEY_BW-1:0]  key_reg;
    logic [WORD_BW-1:0] chain_reg;
    logic [WORD_BW-1:0] word_reg;
    logic [WORD_BW-1:0] cin_reg;
    logic [WORD_BW-1:0] res_reg;
    logic [LEN_BW-1:0]  remain_reg;
    logic [TCNT_BW-1:0] tcnt_reg;
    logic               msg_done_reg;
    logic               timeout_err_reg;

    // ERR behaves like IDLE for start, so a new message also clears the error.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_ERR: begin
                if (start) begin
                    state_next = (num_blocks == '0) ? ST_IDLE : ST_WAIT_IN;
                end
            end
            ST_WAIT_IN: begin
                if (in_valid) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (core.aes_done) begin
                    state_next = ST_OUT;
                end else if (tcnt_reg == TCNT_LAST) begin
                    state_next = ST_ERR;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_next = (remain_reg == LEN_BW'(1)) ? ST_IDLE : ST_WAIT_IN;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state_reg       <= ST_IDLE;
            mode_reg        <= 1'b0;
            key_reg         <= '0;
            chain_reg       <= '0;
            word_reg        <= '0;
            cin_reg         <= '0;
            res_reg         <= '0;
            remain_reg      <= '0;
            tcnt_reg        <= '0;
            msg_done_reg    <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            msg_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_ERR: begin
                    if (start) begin
                        mode_reg        <= mode_in;
                        key_reg         <= key_in;
                        chain_reg       <= iv_in;
                        remain_reg      <= num_blocks;
                        timeout_err_reg <= 1'b0;
                        if (num_blocks == '0) begin
                            msg_done_reg <= 1'b1;
                        end
                    end
                end
                ST_WAIT_IN: begin
                    if (in_valid) begin
                        // Encrypt whitens the plaintext before the core; decrypt keeps the
                        // ciphertext aside because it becomes the next chaining value.
                        word_reg <= mode_reg ? in_data : (in_data ^ chain_reg);
                        cin_reg  <= in_data;
                        tcnt_reg <= '0;
                    end
                end
                ST_RUN: begin
                    if (core.aes_done) begin
                        res_reg   <= mode_reg ? (core.aes_result ^ chain_reg) : core.aes_result;
                        chain_reg <= mode_reg ? cin_reg : core.aes_result;
                    end else if (tcnt_reg == TCNT_LAST) begin
                        timeout_err_reg <= 1'b1;
                    end else begin
                        tcnt_reg <= tcnt_reg + TCNT_BW'(1);
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        remain_reg <= remain_reg - LEN_BW'(1);
                        if (remain_reg == LEN_BW'(1)) begin
                            msg_done_reg <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes decode the state directly so they drop the moment reset asserts.
    assign in_ready    = (state_reg == ST_WAIT_IN);
    assign out_valid   = (state_reg == ST_OUT);
    assign busy        = (state_reg != ST_IDLE);
    assign out_data    = res_reg;
    assign msg_done    = msg_done_reg;
    assign timeout_err = timeout_err_reg;

    assign core.aes_enable = (state_reg == ST_RUN);
    assign core.aes_mode   = mode_reg;
    assign core.aes_key    = key_reg;
    assign core.aes_word   = word_reg;

endmodule

// File: tb/tb_aes_cbc_ctrl.sv
// Directed bench for aes_cbc_ctrl: a 20-cycle AES core stub returning the FIPS-197
// AES-256 vector, driven through enc/dec messages, stalls, timeout, empty message and reset.
module tb_aes_cbc_ctrl;

    localparam logic [255:0] K  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] P2 = 128'h8eb395f9153223c86265e32b87948e76;

    logic         clk = 1'b0;
    logic         srst_n = 1'b0;
    logic         start = 1'b0;
    logic         mode_in = 1'b0;
    logic [255:0] key_in = '0;
    logic [127:0] iv_in = '0;
    logic [15:0]  num_blocks = '0;
    logic         in_valid = 1'b0;
    logic [127:0] in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic [127:0] out_data;
    logic         out_ready = 1'b0;
    logic         busy;
    logic         msg_done;
    logic         timeout_err;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int done_pulses = 0;
    int en_cycles = 0;
    int stub_cnt = 0;
    logic stub_on = 1'b1;

    aes_cbc_ctrl_if core_if ();

    aes_cbc_ctrl dut (
        .clk         (clk),
        .srst_n      (srst_n),
        .start       (start),
        .mode_in     (mode_in),
        .key_in      (key_in),
        .iv_in       (iv_in),
        .num_blocks  (num_blocks),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .busy        (busy),
        .msg_done    (msg_done),
        .timeout_err (timeout_err),
        .core        (core_if)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] stub_aes(input logic m, input logic [127:0] w);
        if (!m && w == P1) return C1;
        if (m && w == C1) return P1;
        return ~w;
    endfunction

    // Core stub: done one cycle, 20 cycles after enable rises; re-arms when enable drops.
    always @(posedge clk) begin
        if (!core_if.aes_enable) begin
            stub_cnt           <= 0;
            core_if.aes_done   <= 1'b0;
            core_if.aes_result <= '0;
        end else begin
            stub_cnt           <= stub_cnt + 1;
            core_if.aes_done   <= stub_on && (stub_cnt == 19);
            core_if.aes_result <= stub_aes(core_if.aes_mode, core_if.aes_word);
        end
    end

    always @(posedge clk) begin
        if (msg_done) done_pulses <= done_pulses + 1;
        if (core_if.aes_enable) en_cycles <= en_cycles + 1;
    end

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_msg(input logic m, input logic [255:0] k, input logic [127:0] iv,
                             input logic [15:0] n);
        mode_in = m; key_in = k; iv_in = iv; num_blocks = n;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_block(input string tag, input logic [127:0] din, input logic [127:0] exp_word,
                              input logic [127:0] exp_out, input logic exp_last, input int stall);
        int n;
        int bad;
        logic [127:0] held;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check_val({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1; in_data = din; out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = '0;
        check_val({tag, "_enable"}, core_if.aes_enable, 1);
        check_val({tag, "_word"}, core_if.aes_word, exp_word);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check_val({tag, "_latency"}, n, 21);
        check_val({tag, "_out_data"}, out_data, exp_out);
        check_val({tag, "_in_ready_in_out"}, in_ready, 0);
        if (stall > 0) begin
            held = out_data; bad = 0;
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                if (out_data !== held || in_ready || core_if.aes_enable || !out_valid) bad++;
            end
            check_val({tag, "_stall_hold"}, bad, 0);
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val({tag, "_msg_done"}, msg_done, exp_last);
        check_val({tag, "_busy"}, busy, !exp_last);
        $display("blk %s in=%h out=%h lat=%0d", tag, din, exp_out, n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int n;
        int n_en;
        int e0;
        int d0;

        repeat (2) @(posedge clk);
        #1;
        check_val("rst_outputs", {busy, in_ready, out_valid, msg_done, timeout_err,
                                  core_if.aes_enable, core_if.aes_mode}, 0);
        check_val("rst_key", core_if.aes_key, 0);
        check_val("rst_word", {core_if.aes_word, out_data}, 0);
        srst_n = 1'b1;
        @(posedge clk); #1;
        $display("txn reset done");

        // single encrypt block
        start_msg(1'b0, K, '0, 16'd1);
        check_val("enc1_key", core_if.aes_key, K);
        check_val("enc1_state", {busy, in_ready, core_if.aes_mode}, 3'b110);
        send_block("enc1", P1, P1, C1, 1'b1, 0);
        @(posedge clk); #1;
        check_val("enc1_done_pulse_end", msg_done, 0);

        // two-block encrypt: chaining turns P2 back into P1 at the core
        start_msg(1'b0, K, '0, 16'd2);
        send_block("enc2a", P1, P1, C1, 1'b0, 0);
        send_block("enc2b", P2, P1, C1, 1'b1, 0);

        // two-block decrypt
        start_msg(1'b1, K, '0, 16'd2);
        check_val("dec_mode", core_if.aes_mode, 1);
        send_block("dec2a", C1, C1, P1, 1'b0, 0);
        send_block("dec2b", C1, C1, P2, 1'b1, 0);

        // downstream stall for 10 cycles
        start_msg(1'b0, K, '0, 16'd2);
        send_block("stall_a", P1, P1, C1, 1'b0, 10);
        send_block("stall_b", P2, P1, C1, 1'b1, 0);

        // core never answers
        stub_on = 1'b0;
        start_msg(1'b0, K, '0, 16'd1);
        in_valid = 1'b1; in_data = P1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0; n_en = 0;
        while (!timeout_err && n < 200) begin
            if (core_if.aes_enable) n_en++;
            @(posedge clk); #1; n++;
        end
        check_val("tmo_run_cycles", n_en, 64);
        check_val("tmo_err_state", {timeout_err, core_if.aes_enable, in_ready, busy}, 4'b1001);
        repeat (3) @(posedge clk);
        #1;
        check_val("tmo_sticky", timeout_err, 1);
        $display("txn timeout after %0d run cycles", n_en);
        stub_on = 1'b1;
        start_msg(1'b0, K, '0, 16'd1);
        check_val("tmo_cleared", {timeout_err, in_ready}, 2'b01);
        send_block("after_tmo", P1, P1, C1, 1'b1, 0);

        // empty message
        e0 = en_cycles;
        start_msg(1'b0, K, '0, 16'd0);
        check_val("empty_done", {msg_done, busy}, 2'b10);
        @(posedge clk); #1;
        check_val("empty_done_end", msg_done, 0);
        repeat (3) @(posedge clk);
        #1;
        check_val("empty_no_enable", en_cycles - e0, 0);
        $display("txn empty message");

        // asynchronous reset in the middle of RUN
        d0 = done_pulses;
        start_msg(1'b0, K, '0, 16'd1);
        in_valid = 1'b1; in_data = P1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_val("rst_mid_pre", core_if.aes_enable, 1);
        #2;
        srst_n = 1'b0;
        #1;
        check_val("rst_mid_flags", {busy, in_ready, out_valid, msg_done, timeout_err,
                                    core_if.aes_enable, core_if.aes_mode}, 0);
        check_val("rst_mid_key", core_if.aes_key, 0);
        check_val("rst_mid_word", core_if.aes_word, 0);
        @(posedge clk); #1;
        srst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check_val("rst_mid_no_done", done_pulses - d0, 0);
        check_val("rst_mid_idle", busy, 0);
        $display("txn reset mid-run");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
